// File: rtl/fractal_sync_pkg.sv
// Shared fractal sync tree types: child port ordering, sync direction encoding and the
// arbiter request payload, which other blocks re-declare at their own widths via the typedef macro.
`ifndef FRACTAL_SYNC_TYPEDEF_ARB_REQ
`define FRACTAL_SYNC_TYPEDEF_ARB_REQ(name_t, lvl_w, id_w) \
    typedef struct packed { \
        logic [(lvl_w)-1:0] lvl; \
        logic [(id_w)-1:0]  id; \
        logic [1:0]         sd; \
    } name_t;
`endif

package fractal_sync_pkg;

    typedef enum logic [1:0] {
        PORT_H01 = 2'd0,
        PORT_V01 = 2'd1,
        PORT_H02 = 2'd2,
        PORT_V02 = 2'd3
    } port_idx_e;

    typedef enum logic [1:0] {
        SD_ILL = 2'b00,
        SD_HOR = 2'b01,
        SD_VER = 2'b10,
        SD_HV  = 2'b11
    } sd_e;

    localparam logic [1:0] SD_ILLEGAL    = 2'b00;
    localparam int         N_CHILD_PORTS = int'(PORT_V02) + 1;
    localparam int         DEF_LVL_WIDTH = 4;
    localparam int         DEF_ID_WIDTH  = 8;

    `FRACTAL_SYNC_TYPEDEF_ARB_REQ(arb_req_t, DEF_LVL_WIDTH, DEF_ID_WIDTH)

    function automatic int src_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/fractal_sync_rr_sel.sv
// Combinational rotating-priority picker: first requester found starting at ptr_i, wrapping.
// Fixed-priority builds drive ptr_i with zero, which turns this into lowest-index-wins.
module fractal_sync_rr_sel
    import fractal_sync_pkg::*;
#(
    parameter int N_PORTS   = N_CHILD_PORTS,
    parameter int SRC_WIDTH = src_width(N_PORTS)
) (
    input  logic [N_PORTS-1:0]   req_i,
    input  logic [SRC_WIDTH-1:0] ptr_i,
    output logic [N_PORTS-1:0]   grant_o,
    output logic [SRC_WIDTH-1:0] idx_o,
    output logic                 any_o
);

    logic [SRC_WIDTH-1:0] cand_s;

    // Scan candidates ptr, ptr+1, ... modulo N_PORTS and keep the first hit
    always_comb begin
        grant_o = '0;
        idx_o   = '0;
        any_o   = 1'b0;
        cand_s  = '0;
        for (int k = 0; k < N_PORTS; k++) begin
            cand_s = SRC_WIDTH'((int'(ptr_i) + k) % N_PORTS);
            if (!any_o && req_i[cand_s]) begin
                grant_o[cand_s] = 1'b1;
                idx_o           = cand_s;
                any_o           = 1'b1;
            end else begin
                any_o = any_o;
            end
        end
    end

endmodule

// File: rtl/fractal_sync_arbiter.sv
// Shares one upstream sync-request channel between the child ports of a fractal sync node.
// Build option: FRACTAL_SYNC_ARB_FIXED_PRIO_EN selects fixed priority instead of round-robin.
module fractal_sync_arbiter
    import fractal_sync_pkg::*;
#(
    parameter int N_PORTS   = N_CHILD_PORTS,
    parameter int LVL_WIDTH = DEF_LVL_WIDTH,
    parameter int ID_WIDTH  = DEF_ID_WIDTH,
    parameter int SRC_WIDTH = src_width(N_PORTS)
) (
    input  logic                           clk_i,
    input  logic                           rst_i,
    input  logic [N_PORTS-1:0]             req_valid_i,
    output logic [N_PORTS-1:0]             req_ready_o,
    input  logic [N_PORTS*LVL_WIDTH-1:0]   req_lvl_i,
    input  logic [N_PORTS*ID_WIDTH-1:0]    req_id_i,
    input  logic [N_PORTS*2-1:0]           req_sd_i,
    output logic                           arb_valid_o,
    input  logic                           arb_ready_i,
    output logic [LVL_WIDTH-1:0]           arb_lvl_o,
    output logic [ID_WIDTH-1:0]            arb_id_o,
    output logic [1:0]                     arb_sd_o,
    output logic [SRC_WIDTH-1:0]           arb_src_o,
    output logic                           err_o,
    output logic                           busy_o
);

    `FRACTAL_SYNC_TYPEDEF_ARB_REQ(req_t, LVL_WIDTH, ID_WIDTH)

    logic [N_PORTS-1:0]   buf_v_q, buf_v_d;
    req_t                 buf_q [N_PORTS];
    req_t                 buf_d [N_PORTS];
    req_t                 out_q, out_d;
    logic                 out_v_q, out_v_d;
    logic [SRC_WIDTH-1:0] src_q, src_d;
    logic                 err_q, err_d;
    logic [SRC_WIDTH-1:0] ptr_s;
    logic [N_PORTS-1:0]   grant_s, hs_s;
    logic [SRC_WIDTH-1:0] sel_s;
    logic                 any_s, load_s;

    fractal_sync_rr_sel #(
        .N_PORTS   (N_PORTS),
        .SRC_WIDTH (SRC_WIDTH)
    ) u_sel (
        .req_i   (buf_v_q),
        .ptr_i   (ptr_s),
        .grant_o (grant_s),
        .idx_o   (sel_s),
        .any_o   (any_s)
    );

    assign load_s      = (~out_v_q | arb_ready_i) & any_s;
    // A buffer being drained this edge can take a new request on the same edge
    assign req_ready_o = ~buf_v_q | (grant_s & {N_PORTS{load_s}});
    assign hs_s        = req_valid_i & req_ready_o;

`ifdef FRACTAL_SYNC_ARB_FIXED_PRIO_EN
    assign ptr_s = '0;
`else
    logic [SRC_WIDTH-1:0] ptr_q, ptr_d;

    // Round-robin pointer moves just past the port served on each load
    always_comb begin
        ptr_d = ptr_q;
        if (load_s) begin
            if (sel_s == SRC_WIDTH'(N_PORTS - 1)) begin
                ptr_d = '0;
            end else begin
                ptr_d = sel_s + SRC_WIDTH'(1);
            end
        end else begin
            ptr_d = ptr_q;
        end
    end

    // Pointer register
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    assign ptr_s = ptr_q;
`endif

    // Buffer next state: drain the granted entry, capture legal requests, flag illegal ones
    always_comb begin
        buf_v_d = buf_v_q & ~(grant_s & {N_PORTS{load_s}});
        err_d   = 1'b0;
        for (int i = 0; i < N_PORTS; i++) begin
            buf_d[i] = buf_q[i];
            if (hs_s[i]) begin
                if (req_sd_i[2*i +: 2] == SD_ILLEGAL) begin
                    err_d = 1'b1;
                end else begin
                    buf_v_d[i] = 1'b1;
                    buf_d[i]   = '{lvl: req_lvl_i[i*LVL_WIDTH +: LVL_WIDTH],
                                   id:  req_id_i[i*ID_WIDTH +: ID_WIDTH],
                                   sd:  req_sd_i[2*i +: 2]};
                end
            end else begin
                buf_d[i] = buf_q[i];
            end
        end
    end

    // Output stage next state: load the winner, empty on accept, otherwise hold
    always_comb begin
        out_d   = out_q;
        out_v_d = out_v_q;
        src_d   = src_q;
        if (load_s) begin
            out_d   = buf_q[sel_s];
            out_v_d = 1'b1;
            src_d   = sel_s;
        end else if (arb_ready_i) begin
            out_v_d = 1'b0;
        end else begin
            out_v_d = out_v_q;
        end
    end

    // Buffer, output stage and error pulse registers
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            buf_v_q <= '0;
            for (int i = 0; i < N_PORTS; i++) begin
                buf_q[i] <= '0;
            end
            out_q   <= '0;
            out_v_q <= 1'b0;
            src_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            buf_v_q <= buf_v_d;
            for (int i = 0; i < N_PORTS; i++) begin
                buf_q[i] <= buf_d[i];
            end
            out_q   <= out_d;
            out_v_q <= out_v_d;
            src_q   <= src_d;
            err_q   <= err_d;
        end
    end

    assign arb_valid_o = out_v_q;
    assign arb_lvl_o   = out_q.lvl;
    assign arb_id_o    = out_q.id;
    assign arb_sd_o    = out_q.sd;
    assign arb_src_o   = src_q;
    assign err_o       = err_q;
    assign busy_o      = (|buf_v_q) | out_v_q;

endmodule

// File: tb/tb_fractal_sync_arbiter.sv
// Self-checking bench for fractal_sync_arbiter: directed scenarios plus a randomized run
// against a transaction-level reference model (honours FRACTAL_SYNC_ARB_FIXED_PRIO_EN).
module tb_fractal_sync_arbiter;

`ifdef FRACTAL_SYNC_ARB_FIXED_PRIO_EN
    localparam bit FIXED = 1'b1;
`else
    localparam bit FIXED = 1'b0;
`endif

    logic        clk, rst;
    logic [3:0]  valid_r, req_ready_o;
    logic [15:0] lvl_r;
    logic [31:0] id_r;
    logic [7:0]  sd_r;
    logic        ardy_r;
    logic        arb_valid_o, err_o, busy_o;
    logic [3:0]  arb_lvl_o;
    logic [7:0]  arb_id_o;
    logic [1:0]  arb_sd_o, arb_src_o;

    int checks = 0;
    int errors = 0;

    // Reference model state: per-port buffered request, output stage, pointer
    int mv[4], mlvl[4], mid[4], msd[4];
    int mov, molvl, moid, mosd, mosrc, merr, mptr;

    fractal_sync_arbiter dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .req_valid_i (valid_r),
        .req_ready_o (req_ready_o),
        .req_lvl_i   (lvl_r),
        .req_id_i    (id_r),
        .req_sd_i    (sd_r),
        .arb_valid_o (arb_valid_o),
        .arb_ready_i (ardy_r),
        .arb_lvl_o   (arb_lvl_o),
        .arb_id_o    (arb_id_o),
        .arb_sd_o    (arb_sd_o),
        .arb_src_o   (arb_src_o),
        .err_o       (err_o),
        .busy_o      (busy_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic set_req(input int p, input int lvl, input int id, input int sd);
        valid_r[p]       = 1'b1;
        lvl_r[p*4 +: 4]  = 4'(lvl);
        id_r[p*8 +: 8]   = 8'(id);
        sd_r[p*2 +: 2]   = 2'(sd);
    endtask

    task automatic apply_reset();
        valid_r = '0; lvl_r = '0; id_r = '0; sd_r = '0; ardy_r = 1'b1;
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            mv[i] = 0; mlvl[i] = 0; mid[i] = 0; msd[i] = 0;
        end
        mov = 0; molvl = 0; moid = 0; mosd = 0; mosrc = 0; merr = 0; mptr = 0;
    endtask

    function automatic int m_pick();
        for (int k = 0; k < 4; k++) begin
            if (mv[(mptr + k) % 4] != 0) return (mptr + k) % 4;
        end
        return -1;
    endfunction

    task automatic test_reset();
        valid_r = '0; ardy_r = 1'b1;
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if ({arb_valid_o, arb_lvl_o, arb_id_o, arb_sd_o, arb_src_o, err_o, busy_o} !== 19'd0) begin
            errors++;
            $display("FAIL reset_outputs got=%h exp=0",
                     {arb_valid_o, arb_lvl_o, arb_id_o, arb_sd_o, arb_src_o, err_o, busy_o});
        end
        rst = 1'b0;
        #1;
        checks++;
        if (req_ready_o !== 4'hF) begin errors++; $display("FAIL reset_ready got=%b exp=1111", req_ready_o); end
        @(negedge clk);
    endtask

    task automatic test_single();
        apply_reset();
        set_req(2, 3, 8'h15, 3);
        tick();
        valid_r = '0;
        checks++;
        if ({arb_valid_o, busy_o} !== 2'b01) begin errors++; $display("FAIL single_c1 valid/busy got=%b exp=01", {arb_valid_o, busy_o}); end
        tick();
        checks++;
        if ({arb_valid_o, arb_lvl_o, arb_id_o, arb_sd_o, arb_src_o, err_o} !== {1'b1, 4'd3, 8'h15, 2'b11, 2'd2, 1'b0}) begin
            errors++;
            $display("FAIL single_out got v=%b lvl=%0d id=%h sd=%b src=%0d err=%b exp v=1 lvl=3 id=15 sd=11 src=2 err=0",
                     arb_valid_o, arb_lvl_o, arb_id_o, arb_sd_o, arb_src_o, err_o);
        end
        tick();
        checks++;
        if ({arb_valid_o, busy_o} !== 2'b00) begin errors++; $display("FAIL single_drain valid/busy got=%b exp=00", {arb_valid_o, busy_o}); end
    endtask

    task automatic test_contention();
        apply_reset();
        for (int r = 0; r < 2; r++) begin
            for (int i = 0; i < 4; i++) set_req(i, i, 8'h40 + 16*r + i, (i % 3) + 1);
            tick();
            valid_r = '0;
            #1;
            checks++;
            if (req_ready_o !== 4'b0001) begin errors++; $display("FAIL cont_ready r=%0d got=%b exp=0001", r, req_ready_o); end
            for (int k = 0; k < 4; k++) begin
                tick();
                checks++;
                if ({arb_valid_o, arb_src_o, arb_id_o} !== {1'b1, 2'(k), 8'(8'h40 + 16*r + k)}) begin
                    errors++;
                    $display("FAIL cont_order r=%0d k=%0d got v=%b src=%0d id=%h exp src=%0d", r, k, arb_valid_o, arb_src_o, arb_id_o, k);
                end
            end
        end
        tick();
    endtask

    task automatic test_back_pressure();
        int exp_src[2];
        int exp_id[2];
        exp_src[0] = FIXED ? 1 : 3;    exp_src[1] = FIXED ? 3 : 1;
        exp_id[0]  = FIXED ? 8'h31 : 8'h23; exp_id[1] = FIXED ? 8'h23 : 8'h31;
        apply_reset();
        ardy_r = 1'b0;
        set_req(1, 1, 8'h21, 2);
        set_req(3, 3, 8'h23, 2);
        tick();
        valid_r = '0;
        set_req(1, 5, 8'h31, 1);
        tick();
        for (int c = 0; c < 5; c++) begin
            set_req(1, 9, 8'hEE, 1);
            set_req(3, 9, 8'hEE, 1);
            #1;
            checks++;
            if (req_ready_o !== 4'b0101) begin errors++; $display("FAIL bp_ready c=%0d got=%b exp=0101", c, req_ready_o); end
            tick();
            checks++;
            if ({arb_valid_o, arb_src_o, arb_id_o, arb_lvl_o, busy_o} !== {1'b1, 2'd1, 8'h21, 4'd1, 1'b1}) begin
                errors++;
                $display("FAIL bp_hold c=%0d got v=%b src=%0d id=%h lvl=%0d exp v=1 src=1 id=21 lvl=1", c, arb_valid_o, arb_src_o, arb_id_o, arb_lvl_o);
            end
        end
        valid_r = '0;
        ardy_r  = 1'b1;
        for (int k = 0; k < 2; k++) begin
            tick();
            checks++;
            if ({arb_valid_o, arb_src_o, arb_id_o} !== {1'b1, 2'(exp_src[k]), 8'(exp_id[k])}) begin
                errors++;
                $display("FAIL bp_drain k=%0d got src=%0d id=%h exp src=%0d id=%h", k, arb_src_o, arb_id_o, exp_src[k], exp_id[k]);
            end
        end
        tick();
        checks++;
        if ({arb_valid_o, busy_o} !== 2'b00) begin errors++; $display("FAIL bp_empty got=%b exp=00", {arb_valid_o, busy_o}); end
    endtask

    task automatic test_illegal_sd();
        apply_reset();
        set_req(1, 5, 8'h77, 0);
        #1;
        checks++;
        if (req_ready_o[1] !== 1'b1) begin errors++; $display("FAIL ill_accept got=%b exp=1", req_ready_o[1]); end
        tick();
        valid_r = '0;
        checks++;
        if ({err_o, arb_valid_o, busy_o} !== 3'b100) begin errors++; $display("FAIL ill_pulse err/valid/busy got=%b exp=100", {err_o, arb_valid_o, busy_o}); end
        tick();
        checks++;
        if ({err_o, arb_valid_o, busy_o} !== 3'b000) begin errors++; $display("FAIL ill_after err/valid/busy got=%b exp=000", {err_o, arb_valid_o, busy_o}); end
    endtask

    task automatic test_wrap();
        apply_reset();
        set_req(2, 2, 8'h02, 1);
        tick();
        valid_r = '0;
        tick();
        tick();
        set_req(0, 0, 8'hA0, 1);
        set_req(3, 3, 8'hA3, 2);
        tick();
        valid_r = '0;
        for (int k = 0; k < 2; k++) begin
            tick();
            checks++;
            if ({arb_valid_o, arb_src_o} !== {1'b1, 2'((FIXED ? 3 * k : 3 - 3 * k))}) begin
                errors++;
                $display("FAIL wrap_order k=%0d got v=%b src=%0d exp src=%0d", k, arb_valid_o, arb_src_o, FIXED ? 3 * k : 3 - 3 * k);
            end
        end
        tick();
    endtask

    task automatic test_async_reset();
        apply_reset();
        for (int i = 0; i < 4; i++) set_req(i, i, 8'hC0 + i, 1);
        tick();
        valid_r = '0;
        tick();
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({arb_valid_o, busy_o, err_o, arb_src_o, arb_id_o} !== 13'd0) begin
            errors++;
            $display("FAIL arst_clear got v=%b busy=%b err=%b src=%0d id=%h exp all 0", arb_valid_o, busy_o, err_o, arb_src_o, arb_id_o);
        end
        @(negedge clk);
        rst = 1'b0;
        set_req(0, 1, 8'hD0, 1);
        set_req(3, 1, 8'hD3, 1);
        tick();
        valid_r = '0;
        for (int k = 0; k < 2; k++) begin
            tick();
            checks++;
            if ({arb_valid_o, arb_src_o} !== {1'b1, 2'(3 * k)}) begin
                errors++;
                $display("FAIL arst_ptr k=%0d got v=%b src=%0d exp src=%0d", k, arb_valid_o, arb_src_o, 3 * k);
            end
        end
        tick();
    endtask

`ifdef FRACTAL_SYNC_ARB_FIXED_PRIO_EN
    task automatic test_fixed_prio();
        apply_reset();
        set_req(0, 0, 8'h10, 1);
        set_req(3, 3, 8'h13, 1);
        tick();
        tick();
        for (int c = 0; c < 6; c++) begin
            #1;
            checks++;
            if (req_ready_o[3] !== 1'b0) begin errors++; $display("FAIL fixed_starve c=%0d got=%b exp=0", c, req_ready_o[3]); end
            checks++;
            if ({arb_valid_o, arb_src_o} !== {1'b1, 2'd0}) begin errors++; $display("FAIL fixed_grant c=%0d got v=%b src=%0d exp src=0", c, arb_valid_o, arb_src_o); end
            tick();
        end
        valid_r = '0;
        tick(); tick(); tick();
    endtask
`endif

    task automatic test_random();
        int          sel;
        bit          load;
        logic [3:0]  exp_rdy;
        logic [18:0] exp_out;
        apply_reset();
        for (int c = 0; c < 600; c++) begin
            valid_r = 4'($urandom);
            lvl_r   = 16'($urandom);
            id_r    = $urandom;
            sd_r    = 8'($urandom);
            ardy_r  = ($urandom_range(0, 3) != 0);
            #1;
            sel  = m_pick();
            load = ((mov == 0) || ardy_r) && (sel >= 0);
            for (int i = 0; i < 4; i++) exp_rdy[i] = (mv[i] == 0) || (load && sel == i);
            checks++;
            if (req_ready_o !== exp_rdy) begin errors++; $display("FAIL rand_ready c=%0d got=%b exp=%b", c, req_ready_o, exp_rdy); end
            @(posedge clk);
            if (load) begin
                mov = 1; molvl = mlvl[sel]; moid = mid[sel]; mosd = msd[sel]; mosrc = sel;
                mv[sel] = 0;
                if (!FIXED) mptr = (sel + 1) % 4;
            end else if (ardy_r) begin
                mov = 0;
            end
            merr = 0;
            for (int i = 0; i < 4; i++) begin
                if (valid_r[i] && exp_rdy[i]) begin
                    if (sd_r[i*2 +: 2] == 2'b00) begin
                        merr = 1;
                    end else begin
                        mv[i] = 1; mlvl[i] = lvl_r[i*4 +: 4]; mid[i] = id_r[i*8 +: 8]; msd[i] = sd_r[i*2 +: 2];
                    end
                end
            end
            @(negedge clk);
            exp_out = {1'(mov), 4'(molvl), 8'(moid), 2'(mosd), 2'(mosrc), 1'(merr),
                       1'((mv[0] | mv[1] | mv[2] | mv[3] | mov) != 0)};
            checks++;
            if ({arb_valid_o, arb_lvl_o, arb_id_o, arb_sd_o, arb_src_o, err_o, busy_o} !== exp_out) begin
                errors++;
                $display("FAIL rand_out c=%0d got=%h exp=%h", c,
                         {arb_valid_o, arb_lvl_o, arb_id_o, arb_sd_o, arb_src_o, err_o, busy_o}, exp_out);
            end
        end
        valid_r = '0;
        ardy_r  = 1'b1;
    endtask

    initial begin
        rst = 1'b1; valid_r = '0; lvl_r = '0; id_r = '0; sd_r = '0; ardy_r = 1'b1;
        @(negedge clk);
        test_reset();
        test_single();
        test_contention();
        test_back_pressure();
        test_illegal_sd();
        test_wrap();
        test_async_reset();
`ifdef FRACTAL_SYNC_ARB_FIXED_PRIO_EN
        test_fixed_prio();
`endif
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
